// File: rtl/fp_mul_scheduler.sv
// Round-robin front end that time-shares one fp16 multiplier between N_REQ requesters.
// A tag FIFO records who issued each in-flight product, so results can be routed back in order.
module fp_mul_scheduler #(
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_REQ-1:0]                  io_req_valid,
  output logic [N_REQ-1:0]                  io_req_ready,
  input  logic [16*N_REQ-1:0]               io_req_a,
  input  logic [16*N_REQ-1:0]               io_req_b,
  output logic [15:0]                       io_mul_a,
  output logic [15:0]                       io_mul_b,
  output logic                              io_mul_valid_in,
  input  logic [15:0]                       io_mul_out,
  input  logic                              io_mul_valid_out,
  output logic [N_REQ-1:0]                  io_resp_valid,
  output logic [15:0]                       io_resp_data,
  output logic [$clog2(MAX_INFLIGHT):0]     io_inflight,
  output logic                              io_err
);

  localparam int TW = $clog2(N_REQ);
  localparam int AW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;

  logic [15:0]      w_req_a [N_REQ];
  logic [15:0]      w_req_b [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_req_a[gi] = io_req_a[16*gi +: 16];
      assign w_req_b[gi] = io_req_b[16*gi +: 16];
    end
  endgenerate

  logic [TW-1:0]    r_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [TW-1:0]    r_tag_mem [MAX_INFLIGHT];
  logic             r_mul_valid;
  logic [15:0]      r_mul_a;
  logic [15:0]      r_mul_b;
  logic [N_REQ-1:0] r_resp_valid;
  logic [15:0]      r_resp_data;
  logic             r_err;

  logic             w_found;
  logic [TW-1:0]    w_gnt;
  logic [TW:0]      w_sum;
  logic [TW-1:0]    w_cand;
  logic             w_can_accept;
  logic             w_issue;
  logic             w_pop;
  logic             w_err_evt;
  logic [N_REQ-1:0] w_ready;
  logic [TW-1:0]    w_ptr_next;
  logic [TW-1:0]    w_head_tag;
  logic [AW-1:0]    w_wr_ptr_next;
  logic [AW-1:0]    w_rd_ptr_next;

  // Scan requesters starting at the pointer; first valid one wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (TW+1)'(k);
      if (w_sum >= (TW+1)'(N_REQ)) begin
        w_sum = w_sum - (TW+1)'(N_REQ);
      end
      w_cand = w_sum[TW-1:0];
      if (!w_found && io_req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
  end

  // Acceptance depends only on the registered count, so a same-cycle pop never re-opens it.
  assign w_can_accept = (r_count < CW'(MAX_INFLIGHT));
  assign w_issue      = w_found & w_can_accept;
  assign w_pop        = io_mul_valid_out & (r_count != '0);
  assign w_err_evt    = io_mul_valid_out & (r_count == '0);
  assign w_head_tag   = r_tag_mem[r_rd_ptr];

  always_comb begin
    w_ready = '0;
    if (w_issue) begin
      w_ready[w_gnt] = 1'b1;
    end
  end

  assign w_ptr_next    = (w_gnt == TW'(N_REQ-1)) ? '0 : w_gnt + 1'b1;
  assign w_wr_ptr_next = (r_wr_ptr == AW'(MAX_INFLIGHT-1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_next = (r_rd_ptr == AW'(MAX_INFLIGHT-1)) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clock) begin
    if (w_issue) begin
      r_tag_mem[r_wr_ptr] <= w_gnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_mul_valid  <= 1'b0;
      r_mul_a      <= 16'h0000;
      r_mul_b      <= 16'h0000;
      r_resp_valid <= '0;
      r_resp_data  <= 16'h0000;
      r_err        <= 1'b0;
    end else begin
      r_mul_valid <= w_issue;
      if (w_issue) begin
        r_mul_a  <= w_req_a[w_gnt];
        r_mul_b  <= w_req_b[w_gnt];
        r_ptr    <= w_ptr_next;
        r_wr_ptr <= w_wr_ptr_next;
      end

      r_resp_valid <= '0;
      if (w_pop) begin
        r_resp_valid[w_head_tag] <= 1'b1;
        r_resp_data              <= io_mul_out;
        r_rd_ptr                 <= w_rd_ptr_next;
      end

      if (w_issue && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_issue && w_pop) begin
        r_count <= r_count - 1'b1;
      end

      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  assign io_req_ready    = w_ready;
  assign io_mul_a        = r_mul_a;
  assign io_mul_b        = r_mul_b;
  assign io_mul_valid_in = r_mul_valid;
  assign io_resp_valid   = r_resp_valid;
  assign io_resp_data    = r_resp_data;
  assign io_inflight     = r_count;
  assign io_err          = r_err;

endmodule
